// File: rtl/asap_poe_ctrl.sv
// Proof-of-execution session controller: ER/OR bound registers on the openMSP430 peripheral bus
// plus the arm/run/done sequencer. Define ASAP_POE_TIMEOUT_EN to build the TIMEOUT register and check.
module asap_poe_ctrl #(
    parameter logic [13:0] PER_BASE = 14'h0090
) (
    input  logic        clk,
    input  logic        puc_n,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    output logic [15:0] per_dout,
    input  logic [15:0] pc,
    input  logic        exec,
    input  logic        hw_reset,
    output logic [15:0] ER_min,
    output logic [15:0] ER_max,
    output logic [15:0] OR_min,
    output logic [15:0] OR_max,
    output logic        locked,
    output logic        irq_done
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArmed   = 3'd1,
        StRunning = 3'd2,
        StDone    = 3'd3,
        StFail    = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  err_q, err_d;
    logic [15:0] er_min_q, er_max_q, or_min_q, or_max_q;
    logic [15:0] cycles_q, cycles_d;
    logic        irq_q, irq_d;

    logic [13:0] off;
    logic [2:0]  idx;
    logic        hit, wr, cfg_wr;
    logic        arm_req, abort_req, clr_req;
    logic        cfg_valid, timeout_hit;

    // Offset relative to the base; addresses below the base wrap to large offsets and miss.
    assign off    = per_addr - PER_BASE;
    assign idx    = off[2:0];
    assign hit    = per_en && (off[13:3] == 11'd0);
    assign wr     = hit && (per_we == 2'b11);
    assign cfg_wr = wr && (state_q == StIdle);

    assign abort_req = wr && (idx == 3'd4) && per_din[1];
    assign arm_req   = wr && (idx == 3'd4) && per_din[0] && !per_din[1];
    assign clr_req   = wr && (idx == 3'd4) && per_din[2];

    // Inclusive ranges: disjoint when one lies wholly below the other.
    assign cfg_valid = (er_min_q < er_max_q) && (or_min_q <= or_max_q) &&
                       ((er_max_q < or_min_q) || (or_max_q < er_min_q));

`ifdef ASAP_POE_TIMEOUT_EN
    logic [15:0] timeout_q;
    assign timeout_hit = (timeout_q != 16'd0) && (cycles_q == timeout_q);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        cycles_d = cycles_q;
        case (state_q)
            StIdle: begin
                if (arm_req) begin
                    if (cfg_valid) begin
                        state_d = StArmed;
                    end else begin
                        state_d = StFail;
                        err_d   = 3'd1;
                    end
                end
            end
            StArmed: begin
                if (hw_reset) begin
                    state_d = StFail;
                    err_d   = 3'd5;
                end else if (abort_req) begin
                    state_d = StIdle;
                end else if (pc == er_min_q) begin
                    state_d  = StRunning;
                    cycles_d = 16'd0;
                end
            end
            StRunning: begin
                if (hw_reset) begin
                    state_d = StFail;
                    err_d   = 3'd5;
                end else if (abort_req) begin
                    state_d = StIdle;
                end else if (pc == er_max_q) begin
                    if (exec) begin
                        state_d = StDone;
                    end else begin
                        state_d = StFail;
                        err_d   = 3'd2;
                    end
                end else if (!exec) begin
                    state_d = StFail;
                    err_d   = 3'd3;
                end else if (timeout_hit) begin
                    state_d = StFail;
                    err_d   = 3'd4;
                end
                // Count only cycles that stay in RUNNING so a timeout leaves CYCLES == TIMEOUT.
                if (state_d == StRunning && cycles_q != 16'hFFFF) begin
                    cycles_d = cycles_q + 16'd1;
                end
            end
            StDone, StFail: begin
                if (clr_req) begin
                    state_d = StIdle;
                    err_d   = 3'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign irq_d = ((state_d == StDone) || (state_d == StFail)) &&
                   !((state_q == StDone) || (state_q == StFail));

    always_ff @(posedge clk) begin
        if (!puc_n) begin
            state_q  <= StIdle;
            err_q    <= 3'd0;
            cycles_q <= 16'd0;
            irq_q    <= 1'b0;
            er_min_q <= 16'd0;
            er_max_q <= 16'd0;
            or_min_q <= 16'd0;
            or_max_q <= 16'd0;
`ifdef ASAP_POE_TIMEOUT_EN
            timeout_q <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            cycles_q <= cycles_d;
            irq_q    <= irq_d;
            if (cfg_wr) begin
                case (idx)
                    3'd0: er_min_q <= per_din;
                    3'd1: er_max_q <= per_din;
                    3'd2: or_min_q <= per_din;
                    3'd3: or_max_q <= per_din;
`ifdef ASAP_POE_TIMEOUT_EN
                    3'd6: timeout_q <= per_din;
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        per_dout = 16'd0;
        if (hit) begin
            case (idx)
                3'd0: per_dout = er_min_q;
                3'd1: per_dout = er_max_q;
                3'd2: per_dout = or_min_q;
                3'd3: per_dout = or_max_q;
                3'd5: per_dout = {9'd0, err_q, 1'b0, state_q};
`ifdef ASAP_POE_TIMEOUT_EN
                3'd6: per_dout = timeout_q;
`endif
                3'd7: per_dout = cycles_q;
                default: per_dout = 16'd0;
            endcase
        end
    end

    assign ER_min   = er_min_q;
    assign ER_max   = er_max_q;
    assign OR_min   = or_min_q;
    assign OR_max   = or_max_q;
    assign locked   = (state_q != StIdle);
    assign irq_done = irq_q;

endmodule
